// File: rtl/execute_if.sv
// Bundle of the signals between the decode/E register, the execute stage,
// the M pipeline register and the forwarding logic.
interface execute_if;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [1:0]  W_stat;
    logic [1:0]  m_stat;
    logic        set_cc;
    logic        M_bubble;

    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;

    modport master (
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
        output W_stat, m_stat, set_cc, M_bubble,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  e_Cnd, e_valE, e_dstE
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
        input  W_stat, m_stat, set_cc, M_bubble,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
        output e_Cnd, e_valE, e_dstE
    );
endinterface

// File: rtl/execute.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition and the
// M pipeline register.
module execute (
    input  logic      clk,
    input  logic      rst_n,
    execute_if.slave  bus
);
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [1:0] S_AOK   = 2'd0;

    logic        zf_reg, sf_reg, of_reg;
    logic [63:0] alu_result;
    logic        alu_of;
    logic        cond;
    logic        cnd;
    logic        cc_write;

    always_comb begin
        alu_result = 64'd0;
        alu_of     = 1'b0;
        case (bus.E_icode)
            I_CMOV:           alu_result = bus.E_valA;
            I_IRMOV:          alu_result = bus.E_valC;
            I_RMMOV, I_MRMOV: alu_result = bus.E_valB + bus.E_valC;
            I_OPQ: begin
                case (bus.E_ifun)
                    4'd0: begin
                        alu_result = bus.E_valB + bus.E_valA;
                        alu_of = (bus.E_valA[63] == bus.E_valB[63]) &&
                                 (alu_result[63] != bus.E_valA[63]);
                    end
                    4'd1: begin
                        alu_result = bus.E_valB - bus.E_valA;
                        alu_of = (bus.E_valB[63] != bus.E_valA[63]) &&
                                 (alu_result[63] != bus.E_valB[63]);
                    end
                    4'd2:    alu_result = bus.E_valB & bus.E_valA;
                    4'd3:    alu_result = bus.E_valB ^ bus.E_valA;
                    default: alu_result = 64'd0;
                endcase
            end
            I_CALL, I_PUSH:   alu_result = bus.E_valB - 64'd8;
            I_RET, I_POP:     alu_result = bus.E_valB + 64'd8;
            default:          alu_result = 64'd0;
        endcase
    end

    // Condition is judged on the CC as registered, so an OPq only affects the
    // instruction behind it.
    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = (sf_reg ^ of_reg) | zf_reg;
            4'd2:    cond = sf_reg ^ of_reg;
            4'd3:    cond = zf_reg;
            4'd4:    cond = ~zf_reg;
            4'd5:    cond = ~(sf_reg ^ of_reg);
            4'd6:    cond = ~(sf_reg ^ of_reg) & ~zf_reg;
            default: cond = 1'b0;
        endcase
    end

    assign cnd        = ((bus.E_icode == I_CMOV) || (bus.E_icode == I_JXX)) ? cond : 1'b0;
    assign bus.e_Cnd  = cnd;
    assign bus.e_valE = alu_result;
    assign bus.e_dstE = ((bus.E_icode == I_CMOV) && !cnd) ? RNONE : bus.E_dstE;

    // Excepting instructions downstream must not let a younger OPq alter state.
    assign cc_write = bus.set_cc && (bus.E_icode == I_OPQ) && (bus.E_stat == S_AOK) &&
                      (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_reg <= 1'b1;
            sf_reg <= 1'b0;
            of_reg <= 1'b0;
        end else if (cc_write) begin
            zf_reg <= (alu_result == 64'd0);
            sf_reg <= alu_result[63];
            of_reg <= alu_of;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.M_stat  <= 2'd0;
            bus.M_icode <= I_NOP;
            bus.M_Cnd   <= 1'b0;
            bus.M_valE  <= 64'd0;
            bus.M_valA  <= 64'd0;
            bus.M_dstE  <= RNONE;
            bus.M_dstM  <= RNONE;
        end else if (bus.M_bubble) begin
            bus.M_stat  <= 2'd0;
            bus.M_icode <= I_NOP;
            bus.M_Cnd   <= 1'b0;
            bus.M_valE  <= 64'd0;
            bus.M_valA  <= 64'd0;
            bus.M_dstE  <= RNONE;
            bus.M_dstM  <= RNONE;
        end else begin
            bus.M_stat  <= bus.E_stat;
            bus.M_icode <= bus.E_icode;
            bus.M_Cnd   <= cnd;
            bus.M_valE  <= alu_result;
            bus.M_valA  <= bus.E_valA;
            bus.M_dstE  <= bus.e_dstE;
            bus.M_dstM  <= bus.E_dstM;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage; stimulus queues expected
// results, a negedge monitor pops and compares them.
module tb_execute;
    logic clk;
    logic rst_n;
    execute_if bus();

    execute dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [1:0]  wstat;
        logic [1:0]  mstat;
        logic        setcc;
        logic        bubble;
        logic [63:0] x_valE;
        logic        x_cnd;
        logic [3:0]  x_dstE;
    } vec_t;

    vec_t e_q[$];
    vec_t m_q[$];
    vec_t ev, mv, t;
    logic vec_valid;
    logic m_pending;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] valC, input logic [63:0] valA,
                                input logic [63:0] valB, input logic [3:0] dstE,
                                input logic setcc, input logic bubble,
                                input logic [63:0] x_valE, input logic x_cnd,
                                input logic [3:0] x_dstE);
        vec_t r;
        r.stat = 2'd0; r.icode = icode; r.ifun = ifun; r.valC = valC;
        r.valA = valA; r.valB = valB; r.dstE = dstE; r.dstM = 4'h5;
        r.wstat = 2'd0; r.mstat = 2'd0; r.setcc = setcc; r.bubble = bubble;
        r.x_valE = x_valE; r.x_cnd = x_cnd; r.x_dstE = x_dstE;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        bus.E_stat = v.stat;   bus.E_icode = v.icode; bus.E_ifun = v.ifun;
        bus.E_valC = v.valC;   bus.E_valA = v.valA;   bus.E_valB = v.valB;
        bus.E_dstE = v.dstE;   bus.E_dstM = v.dstM;   bus.W_stat = v.wstat;
        bus.m_stat = v.mstat;  bus.set_cc = v.setcc;  bus.M_bubble = v.bubble;
        vec_valid = 1'b1;
        e_q.push_back(v);
        m_q.push_back(v);
        $display("vec icode=%0d ifun=%0d valA=%0h valB=%0h valC=%0h set_cc=%0b bubble=%0b exp_valE=%0h",
                 v.icode, v.ifun, v.valA, v.valB, v.valC, v.setcc, v.bubble, v.x_valE);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_pending <= 1'b0;
        else        m_pending <= vec_valid;
    end

    always @(negedge clk) begin
        if (m_pending) begin
            if (m_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL m_queue: got empty expected entry at %0t", $time);
            end else begin
                mv = m_q.pop_front();
                if (mv.bubble) begin
                    chk("M_stat",  64'(bus.M_stat),  64'd0);
                    chk("M_icode", 64'(bus.M_icode), 64'd1);
                    chk("M_Cnd",   64'(bus.M_Cnd),   64'd0);
                    chk("M_valE",  bus.M_valE,       64'd0);
                    chk("M_valA",  bus.M_valA,       64'd0);
                    chk("M_dstE",  64'(bus.M_dstE),  64'hF);
                    chk("M_dstM",  64'(bus.M_dstM),  64'hF);
                end else begin
                    chk("M_stat",  64'(bus.M_stat),  64'(mv.stat));
                    chk("M_icode", 64'(bus.M_icode), 64'(mv.icode));
                    chk("M_Cnd",   64'(bus.M_Cnd),   64'(mv.x_cnd));
                    chk("M_valE",  bus.M_valE,       mv.x_valE);
                    chk("M_valA",  bus.M_valA,       mv.valA);
                    chk("M_dstE",  64'(bus.M_dstE),  64'(mv.x_dstE));
                    chk("M_dstM",  64'(bus.M_dstM),  64'(mv.dstM));
                end
            end
        end
        if (vec_valid) begin
            if (e_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL e_queue: got empty expected entry at %0t", $time);
            end else begin
                ev = e_q.pop_front();
                chk("e_valE", bus.e_valE,      ev.x_valE);
                chk("e_Cnd",  64'(bus.e_Cnd),  64'(ev.x_cnd));
                chk("e_dstE", 64'(bus.e_dstE), 64'(ev.x_dstE));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] BIG = 64'h4000_0000_0000_0000;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    initial begin
        checks = 0; errors = 0; vec_valid = 1'b0;
        rst_n = 1'b0;
        bus.E_stat = 2'd0; bus.E_icode = 4'h7; bus.E_ifun = 4'd3; bus.E_valC = 64'd0;
        bus.E_valA = 64'd0; bus.E_valB = 64'd0; bus.E_dstE = 4'hF; bus.E_dstM = 4'hF;
        bus.W_stat = 2'd0; bus.m_stat = 2'd0; bus.set_cc = 1'b0; bus.M_bubble = 1'b0;
        #12;
        chk("rst_M_stat",  64'(bus.M_stat),  64'd0);
        chk("rst_M_icode", 64'(bus.M_icode), 64'd1);
        chk("rst_M_Cnd",   64'(bus.M_Cnd),   64'd0);
        chk("rst_M_valE",  bus.M_valE,       64'd0);
        chk("rst_M_valA",  bus.M_valA,       64'd0);
        chk("rst_M_dstE",  64'(bus.M_dstE),  64'hF);
        chk("rst_M_dstM",  64'(bus.M_dstM),  64'hF);
        chk("rst_e_Cnd",   64'(bus.e_Cnd),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // CC starts as ZF=1
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b1, 4'hF));
        // 75 - 70 sets ZF=0 SF=0 OF=0
        apply(mk(4'h6, 4'd1, 64'd0, 64'd70, 64'd75, 4'd3, 1'b1, 1'b0, 64'd5, 1'b0, 4'd3));
        apply(mk(4'h7, 4'd6, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b1, 4'hF));
        // signed overflow on add: SF=1 OF=1
        apply(mk(4'h6, 4'd0, 64'd0, BIG, BIG, 4'd2, 1'b1, 1'b0, MIN, 1'b0, 4'd2));
        apply(mk(4'h7, 4'd2, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        apply(mk(4'h7, 4'd5, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b1, 4'hF));
        // 5 - 5 blocked by set_cc=0, m_stat, W_stat, E_stat in turn
        apply(mk(4'h6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd4, 1'b0, 1'b0, 64'd0, 1'b0, 4'd4));
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        t = mk(4'h6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd4, 1'b1, 1'b0, 64'd0, 1'b0, 4'd4);
        t.mstat = 2'd2;
        apply(t);
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        t = mk(4'h6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd4, 1'b1, 1'b0, 64'd0, 1'b0, 4'd4);
        t.wstat = 2'd3;
        apply(t);
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        t = mk(4'h6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd4, 1'b1, 1'b0, 64'd0, 1'b0, 4'd4);
        t.stat = 2'd2;
        apply(t);
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        // now allowed: ZF=1
        apply(mk(4'h6, 4'd1, 64'd0, 64'd5, 64'd5, 4'd4, 1'b1, 1'b0, 64'd0, 1'b0, 4'd4));
        apply(mk(4'h2, 4'd3, 64'd0, 64'd99, 64'd0, 4'd7, 1'b0, 1'b0, 64'd99, 1'b1, 4'd7));
        apply(mk(4'h2, 4'd4, 64'd0, 64'd99, 64'd0, 4'd7, 1'b0, 1'b0, 64'd99, 1'b0, 4'hF));
        // address and stack arithmetic
        apply(mk(4'h4, 4'd0, 64'd55, 64'd1, 64'd50, 4'hF, 1'b0, 1'b0, 64'd105, 1'b0, 4'hF));
        apply(mk(4'h5, 4'd0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd0, 64'd100, 4'hF, 1'b0, 1'b0, 64'd80, 1'b0, 4'hF));
        apply(mk(4'h8, 4'd0, 64'd0, 64'd0, 64'd135, 4'd4, 1'b0, 1'b0, 64'd127, 1'b0, 4'd4));
        apply(mk(4'hB, 4'd0, 64'd0, 64'd0, 64'd165, 4'd4, 1'b0, 1'b0, 64'd173, 1'b0, 4'd4));
        apply(mk(4'hA, 4'd0, 64'd0, 64'd0, 64'd200, 4'd4, 1'b0, 1'b0, 64'd192, 1'b0, 4'd4));
        apply(mk(4'h9, 4'd0, 64'd0, 64'd0, 64'd300, 4'd4, 1'b0, 1'b0, 64'd308, 1'b0, 4'd4));
        apply(mk(4'h3, 4'd0, 64'd40, 64'd0, 64'd0, 4'd6, 1'b0, 1'b0, 64'd40, 1'b0, 4'd6));
        // bubbled OPq still writes CC (ZF=0 SF=0 OF=0)
        apply(mk(4'h6, 4'd2, 64'd0, 64'hF0, 64'h3C, 4'd10, 1'b1, 1'b1, 64'h30, 1'b0, 4'd10));
        apply(mk(4'h7, 4'd1, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        apply(mk(4'h6, 4'd3, 64'd0, 64'd5, 64'd5, 4'd1, 1'b0, 1'b0, 64'd0, 1'b0, 4'd1));
        apply(mk(4'h6, 4'd4, 64'd0, 64'd5, 64'd9, 4'd1, 1'b0, 1'b0, 64'd0, 1'b0, 4'd1));
        apply(mk(4'h7, 4'd7, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        apply(mk(4'h7, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b1, 4'hF));
        apply(mk(4'h1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        t = mk(4'h0, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF);
        t.stat = 2'd1;
        apply(t);
        // sub overflow: MIN - 1 gives SF=0 OF=1
        apply(mk(4'h6, 4'd1, 64'd0, 64'd1, MIN, 4'd2, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'd2));
        apply(mk(4'h7, 4'd2, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b1, 4'hF));
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b0, 4'hF));
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        repeat (2) @(posedge clk);

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_M_icode", 64'(bus.M_icode), 64'd1);
        chk("midrst_M_dstM",  64'(bus.M_dstM),  64'hF);
        $display("mid-cycle reset applied");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0, 64'd0, 1'b1, 4'hF));
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        repeat (3) @(posedge clk);

        chk("queues_drained", 64'(e_q.size() + m_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
